// File: rtl/bwc_pkg.sv
// Shared types and constants for the bounded walk counter.
package bwc_pkg;

    localparam int unsigned BWC_W         = 11;
    localparam int unsigned BWC_N_CH      = 4;
    localparam int unsigned BWC_BOUND_RST = 300;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bwc_state_t;

    // Largest bound that still leaves j = m + 1 representable in w bits.
    function automatic int unsigned sat_bound(input int unsigned w);
        return (32'd1 << w) - 32'd2;
    endfunction

endpackage

// File: rtl/bwc_chan.sv
// One channel accumulator: steps up or down by one, never below zero.
module bwc_chan
    import bwc_pkg::*;
#(
    parameter int unsigned W = BWC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         step,
    input  logic         sel,
    output logic [W-1:0] a,
    output logic         moves
);

    // A decrement request on an empty accumulator is a non-move.
    assign moves = sel | (a != '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a <= '0;
        end else if (step && moves) begin
            a <= sel ? a + W'(1) : a - W'(1);
        end
    end

endmodule

// File: rtl/bounded_walk_ctr.sv
// Multi-channel bounded up/down walk counter with shared step counter j and loadable bound m.
// Define BWC_PROP_CHK_EN to add the built-in invariant assertions.
module bounded_walk_ctr
    import bwc_pkg::*;
#(
    parameter int unsigned W         = BWC_W,
    parameter int unsigned N_CH      = BWC_N_CH,
    parameter int unsigned BOUND_RST = BWC_BOUND_RST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_CH-1:0]   sel,
    input  logic              load,
    input  logic [W-1:0]      bound_in,
    output logic              load_ack,
    output logic [N_CH*W-1:0] a,
    output logic [W-1:0]      j,
    output logic [W-1:0]      m,
    output logic              done,
    output logic              busy
);

    localparam logic [W-1:0] SAT = W'(sat_bound(W));

    bwc_state_t      state;
    logic            load_take;
    logic            step;
    logic            any_move;
    logic [N_CH-1:0] moves;
    logic [W-1:0]    j_inc;
    logic [W-1:0]    bound_sat;

    always_comb begin
        load_take = load && ((state == IDLE) || (state == DONE));
        step      = (state == RUN) && en && (j <= m);
        any_move  = |moves;
        j_inc     = j + W'(1);
        bound_sat = (bound_in > SAT) ? SAT : bound_in;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        bwc_chan #(
            .W(W)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .clr  (load_take),
            .step (step),
            .sel  (sel[g]),
            .a    (a[g*W +: W]),
            .moves(moves[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            j        <= W'(1);
            m        <= W'(BOUND_RST);
            load_ack <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
        end else begin
            load_ack <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (load) begin
                        m        <= bound_sat;
                        j        <= W'(1);
                        load_ack <= 1'b1;
                        done     <= 1'b0;
                        if (bound_sat != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (j > m) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (en && any_move) begin
                        j <= j_inc;
                        if (j_inc > m) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BWC_PROP_CHK_EN
    bwc_state_t state_prev;

    always_ff @(posedge clk) begin
        state_prev <= state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                assert (a[i*W +: W] <= m)
                    else $error("bwc: a[%0d] exceeds m", i);
                assert ({1'b0, a[i*W +: W]} + 1'b1 <= {1'b0, j})
                    else $error("bwc: a[%0d] exceeds j-1", i);
            end
            assert ({1'b0, j} <= {1'b0, m} + 1'b1)
                else $error("bwc: j exceeds m+1 (channel -1)");
            assert ((state == IDLE) || (done == (j > m)))
                else $error("bwc: done disagrees with j>m (channel -1)");
            assert (!load_ack || (state_prev == IDLE) || (state_prev == DONE))
                else $error("bwc: load_ack outside IDLE/DONE (channel -1)");
        end
    end
`endif

endmodule

// File: tb/tb_bounded_walk_ctr.sv
// Scoreboard bench for bounded_walk_ctr: driver feeds a spec-level model, monitor compares each cycle.
module tb_bounded_walk_ctr;

    localparam int W    = 11;
    localparam int N_CH = 4;
    localparam int BRST = 300;
    localparam int SATB = 2046;

    logic              clk = 1'b0;
    logic              rst, en, load;
    logic [N_CH-1:0]   sel;
    logic [W-1:0]      bound_in;
    logic              load_ack, done, busy;
    logic [N_CH*W-1:0] a;
    logic [W-1:0]      j, m;

    bounded_walk_ctr #(.W(W), .N_CH(N_CH), .BOUND_RST(BRST)) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .load(load), .bound_in(bound_in),
        .load_ack(load_ack), .a(a), .j(j), .m(m), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH*W-1:0] a;
        int                j;
        int                m;
        bit                done;
        bit                busy;
        bit                ack;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: plain integers, mode as a string.
    int    ma[N_CH];
    int    mj, mm;
    string mode;

    task automatic model_edge(input bit r, input bit e, input bit [N_CH-1:0] s,
                              input bit l, input int b);
        exp_t x;
        bit   ack = 0;
        if (r) begin
            foreach (ma[i]) ma[i] = 0;
            mj = 1; mm = BRST; mode = "run";
        end else if (l && (mode == "idle" || mode == "done")) begin
            mm = (b > SATB) ? SATB : b;
            mj = 1;
            foreach (ma[i]) ma[i] = 0;
            ack = 1;
            mode = (mm >= 1) ? "run" : "idle";
        end else if (mode == "run") begin
            if (mj > mm) begin
                mode = "done";
            end else if (e) begin
                int moved = 0;
                foreach (ma[i]) begin
                    if (s[i]) begin ma[i]++; moved++; end
                    else if (ma[i] > 0) begin ma[i]--; moved++; end
                end
                if (moved > 0) mj++;
                if (mj > mm) mode = "done";
            end
        end
        for (int i = 0; i < N_CH; i++) x.a[i*W +: W] = W'(ma[i]);
        x.j = mj; x.m = mm; x.ack = ack;
        x.done = (mode == "done");
        x.busy = (mode == "run");
        sb.push_back(x);
    endtask

    task automatic drive(input bit r, input bit e, input bit [N_CH-1:0] s,
                         input bit l, input int b);
        @(negedge clk);
        rst = r; en = e; sel = s; load = l; bound_in = W'(b);
        model_edge(r, e, s, l, b);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are registered and valid every cycle, one expectation per edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("a",        64'(a),        64'(x.a));
                chk("j",        64'(j),        64'(x.j));
                chk("m",        64'(m),        64'(x.m));
                chk("done",     64'(done),     64'(x.done));
                chk("busy",     64'(busy),     64'(x.busy));
                chk("load_ack", 64'(load_ack), 64'(x.ack));
            end
        end
    end

    initial begin
        rst = 1; en = 0; sel = '0; load = 0; bound_in = '0;
        mode = "run"; mj = 1; mm = BRST;
        foreach (ma[i]) ma[i] = 0;

        drive(1, 0, 4'h0, 0, 0);
        drive(1, 1, 4'hF, 1, 7);     // rst beats load/en
        repeat (300) drive(0, 1, 4'hF, 0, 0);
        repeat (5) drive(0, 1, 4'hF, 0, 0);
        drive(0, 1, 4'hF, 1, 5);     // load wins over en in DONE
        repeat (5) drive(0, 1, 4'hF, 0, 0);
        repeat (3) drive(0, 1, 4'h3, 0, 0);

        drive(1, 0, 4'h0, 0, 0);
        repeat (20) drive(0, 1, 4'h0, 0, 0);
        repeat (10) drive(0, 1, 4'h5, 0, 0);
        repeat (7) drive(0, 1, 4'h0, 0, 0);
        drive(0, 0, 4'hF, 0, 0);
        drive(0, 1, 4'hA, 1, 9);     // load mid-RUN ignored
        repeat (4) drive(0, 1, 4'hF, 0, 0);
        drive(1, 1, 4'hF, 0, 0);     // rst mid-RUN
        drive(0, 0, 4'h0, 0, 0);

        drive(1, 0, 4'h0, 0, 0);
        repeat (301) drive(0, 1, 4'hF, 0, 0);
        drive(0, 0, 4'h0, 1, 0);     // to IDLE
        repeat (3) drive(0, 1, 4'hF, 0, 0);
        drive(0, 0, 4'h0, 1, 2047);  // saturates to 2046
        repeat (6) drive(0, 1, 4'h9, 1, 3);
        drive(0, 0, 4'h0, 0, 0);

        drive(1, 0, 4'h0, 0, 0);
        drive(0, 0, 4'h0, 0, 0);
        repeat (3000) begin
            bit r = ($urandom_range(0, 299) == 0);
            bit e = ($urandom_range(0, 7) != 0);
            bit l = ($urandom_range(0, 7) == 0);
            int b = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2040, 2047))
                                                : int'($urandom_range(0, 12));
            drive(r, e, 4'($urandom), l, b);
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bounded_walk_ctr.md
Name: bounded_walk_ctr

Overview:
- Multi-channel bounded up/down walk counter for the property-mining arithmetic suite.
- One shared step counter j runs from 1 up to a loadable bound m. Each of N_CH channel accumulators a[i] steps up or down per its selector bit on every advancing cycle.
- Provides a done flag, reload handshake and an optional built-in invariant checker.
- Standalone DUT for invariant mining; no upstream/downstream blocks.

Parameters:
W, 11, width of a[i], j, m, bound_in
N_CH, 4, number of channel accumulators
BOUND_RST, 300, value of m after reset; must be <= 2^W-2

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
en  input  1  step enable; no state change when low (except load)
sel  input  N_CH  per-channel direction: 1 = increment, 0 = decrement
load  input  1  request new bound; accepted only in IDLE or DONE
bound_in  input  W  new bound for m
load_ack  output  1  one-cycle pulse: load accepted
a  output  N_CH*W  channel accumulators, channel i at bits [i*W +: W]
j  output  W  shared step counter
m  output  W  current bound
done  output  1  high while state == DONE
busy  output  1  high while state == RUN

Behaviour:
- Reset values: a[i]=0 for all i, j=1, m=BOUND_RST, state=RUN, load_ack=0. rst overrides load/en in the same cycle.
- States: IDLE, RUN, DONE. IDLE is reachable only via load with bound_in==0.
- RUN with en=1 and j<=m:
  - Channel i moves iff sel[i]=1, or sel[i]=0 and a[i]>0.
  - Moving channel: a[i] +1 (sel=1) or -1 (sel=0). Non-moving channel holds; no underflow ever.
  - If at least one channel moves: j <= j+1. If none moves (all sel=0 and all a=0): j holds.
  - If the new j > m, go to DONE on the same edge.
- RUN with en=0: everything holds.
- RUN with j>m cannot persist; next edge forces DONE with no arithmetic.
- DONE: a, j, m hold regardless of en/sel.
- load in IDLE or DONE:
  - Next edge: m <= min(bound_in, 2^W-2) (saturate so j=m+1 is representable); j <= 1; all a[i] <= 0; load_ack=1 for one cycle.
  - State <= RUN if the saturated bound >= 1, else IDLE.
- load in RUN: ignored, no load_ack. en/sel processed normally.
- load and en together in DONE: load wins; no step that cycle.
- Latency: one cycle from inputs to registered outputs. All outputs registered.
- Guaranteed invariants:
  - a[i] <= j-1
  - j <= m+1
  - therefore a[i] <= m
  - done == (j > m) whenever state != IDLE
- Arithmetic is unsigned W-bit. Given the invariants, no wrap is possible.

Optional Feature:
- Macro BWC_PROP_CHK_EN.
- Defined: adds a clocked immediate-assertion block, active when not in reset, checking each cycle:
  - a[i] <= m and a[i] <= j-1 for all i
  - j <= m+1
  - done == (j>m) outside IDLE
  - load_ack implies the previous state was IDLE or DONE
  - A failure calls $error with the channel index.
- Undefined: the block is absent. Functional behaviour is identical and there is zero logic impact.

Decomposition:
- Package bwc_pkg: state enum (IDLE, RUN, DONE); localparam function sat_bound(W) = 2^W-2; default W / N_CH / BOUND_RST constants.
- Sub-module bwc_chan, instantiated N_CH times:
  - Inputs: step, sel.
  - Outputs: a, moves.
  - Holds one W-bit accumulator with the no-underflow rule.
  - The top ORs the moves bits to advance j and runs the FSM.

Test Plan:
- Reset, then en=1, sel=all 1 for 300 cycles -> all a=300, j=301, done=1. Further cycles: all hold.
- After reset, en=1, sel=all 0 -> a=0 and j=1 hold forever; busy=1, done=0.
- sel=4'b0101 for 10 cycles, then 4'b0000 for 7 cycles:
  - ch0/ch2 reach 10 then 3.
  - ch1/ch3 stay 0.
  - j=18.
- In DONE, load=1, bound_in=5 -> load_ack pulse, m=5, j=1, a=0, RUN. Then 5 steps with sel=all 1 -> done, a=5, j=6.
- load=1, bound_in=2^W-1 (2047) -> m=2046. load with bound_in=0 -> IDLE, done=0, busy=0.
- load asserted mid-RUN -> no load_ack, m unchanged. rst asserted mid-RUN -> next cycle a=0, j=1, m=300, RUN.
